// File: rtl/irq_hub_pkg.sv
// rtl/irq_hub_pkg.sv - register map constants shared by the irq_hub block
package irq_hub_pkg;

  localparam logic [1:0] IRQ_REG_STATUS  = 2'd0;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd1;
  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd2;
  localparam logic [1:0] IRQ_REG_ACTIVE  = 2'd3;

  localparam int IRQ_ACTIVE_VALID_BIT = 31;
  localparam int IRQ_MAX              = 32;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder feeding the ACTIVE register
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_hub.sv
// rtl/irq_hub.sv - per-channel pending/enable interrupt hub with register slave
// Optional IRQ_HUB_SYNC_EN adds a 2-flop synchroniser on every source.
module irq_hub
  import irq_hub_pkg::*;
#(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [1:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wrdata,
  input  logic               reg_rd,
  output logic [31:0]        reg_rddata,
  output logic               reg_rdvalid,
  output logic [NUM_IRQ-1:0] irq_out,
  output logic               irq_any
);

  generate
    if (NUM_IRQ < 1 || NUM_IRQ > IRQ_MAX) begin : g_bad_num_irq
      $fatal(1, "irq_hub: NUM_IRQ must be 1..32");
    end
  endgenerate

  logic [NUM_IRQ-1:0] src_s;

`ifdef IRQ_HUB_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  logic [NUM_IRQ-1:0] hist_q, hist_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [31:0]        rddata_q, rddata_d;
  logic               rdvalid_q, rdvalid_d;

  logic [NUM_IRQ-1:0] wr_bits, w1c, rise;
  logic [31:0]        status_w, pending_w, enable_w, active_w, rd_word;
  logic               act_valid;
  logic [4:0]         act_idx;
  logic               unused_wrdata;

  assign wr_bits       = reg_wrdata[NUM_IRQ-1:0];
  assign unused_wrdata = ^reg_wrdata;
  assign irq_out       = pending_q & enable_q;
  assign irq_any       = |irq_out;
  assign reg_rddata    = rddata_q;
  assign reg_rdvalid   = rdvalid_q;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (irq_out),
    .valid (act_valid),
    .idx   (act_idx)
  );

  always_comb begin
    w1c       = (reg_wr && reg_addr == IRQ_REG_PENDING) ? wr_bits : '0;
    rise      = src_s & ~hist_q;
    hist_d    = src_s;
    // A fresh edge beats a same-cycle W1C; level channels simply mirror the source.
    pending_d = (EDGE_MASK & ((pending_q & ~w1c) | rise)) | (~EDGE_MASK & src_s);
    enable_d  = (reg_wr && reg_addr == IRQ_REG_ENABLE) ? wr_bits : enable_q;

    status_w  = '0;
    pending_w = '0;
    enable_w  = '0;
    active_w  = '0;
    status_w[NUM_IRQ-1:0]  = src_s;
    pending_w[NUM_IRQ-1:0] = pending_q;
    enable_w[NUM_IRQ-1:0]  = enable_q;
    active_w[IRQ_ACTIVE_VALID_BIT] = act_valid;
    active_w[4:0]                  = act_idx;

    case (reg_addr)
      IRQ_REG_STATUS:  rd_word = status_w;
      IRQ_REG_PENDING: rd_word = pending_w;
      IRQ_REG_ENABLE:  rd_word = enable_w;
      default:         rd_word = active_w;
    endcase

    rddata_d  = reg_rd ? rd_word : '0;
    rdvalid_d = reg_rd;
  end

  // History resets high so a source held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '1;
      pending_q <= '0;
      enable_q  <= '0;
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
    end
  end

endmodule
